// File: rtl/cla_div_pkg.sv
// Shared types and constants for the cla_div_clk sequential divider.
// Optional two's complement mode is selected with CLA_DIV_SIGNED_EN.
package cla_div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a two's complement value; 0x80000000 maps to itself,
    // which is still correct when read as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with a group carry chain.
// Purely combinational; used as the trial subtractor of cla_div_clk.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    logic [31:0] gen;
    logic [31:0] prop;
    logic [31:0] carry;
    logic [8:0]  grp_c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        grp_c[0] = ci;
        for (int g = 0; g < 8; g++) begin
            grp_g[g] = gen[4*g+3]
                     | (prop[4*g+3] & gen[4*g+2])
                     | (prop[4*g+3] & prop[4*g+2] & gen[4*g+1])
                     | (prop[4*g+3] & prop[4*g+2] & prop[4*g+1] & gen[4*g]);
            grp_p[g] = &prop[4*g +: 4];
            grp_c[g+1] = grp_g[g] | (grp_p[g] & grp_c[g]);
        end
    end

    // Bit carries inside each group derive from that group's lookahead carry-in.
    always_comb begin
        carry = '0;
        for (int g = 0; g < 8; g++) begin
            carry[4*g]   = grp_c[g];
            carry[4*g+1] = gen[4*g] | (prop[4*g] & grp_c[g]);
            carry[4*g+2] = gen[4*g+1] | (prop[4*g+1] & gen[4*g])
                         | (prop[4*g+1] & prop[4*g] & grp_c[g]);
            carry[4*g+3] = gen[4*g+2] | (prop[4*g+2] & gen[4*g+1])
                         | (prop[4*g+2] & prop[4*g+1] & gen[4*g])
                         | (prop[4*g+2] & prop[4*g+1] & prop[4*g] & grp_c[g]);
        end
    end

    assign s  = prop ^ carry;
    assign co = grp_c[8];

endmodule

// File: rtl/cla_div_clk.sv
// Sequential 32-bit restoring divider, one quotient bit per clock, using cla32 as trial subtractor.
// Define CLA_DIV_SIGNED_EN for two's complement operands; default build is unsigned only.
module cla_div_clk
    import cla_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a request with no ready, taken only when busy is low
    // (IDLE); done is a one-cycle strobe, results hold until the next done.

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               div0_q;

    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH-1:0]   dvs_n;
    logic [WIDTH-1:0]   trial_s;
    logic               trial_co;
    logic               take;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   q_out;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   div0_rem;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;

    // Bit shifted out of rem is the 33rd trial bit; when set the trial always fits.
    assign rem_sh   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign dvs_n    = ~dvs_q;
    assign take     = trial_co | rem_q[WIDTH-1];
    assign rem_next = take ? trial_s : rem_sh;
    assign quo_next = {quo_q[WIDTH-2:0], take};

    cla32 u_trial (
        .a  (rem_sh),
        .b  (dvs_n),
        .ci (1'b1),
        .s  (trial_s),
        .co (trial_co)
    );

`ifdef CLA_DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] orig_q;

    assign dividend_mag = abs_val(dividend);
    assign divisor_mag  = abs_val(divisor);
    assign q_out        = neg_q ? (~quo_next + 1'b1) : quo_next;
    assign r_out        = neg_r ? (~rem_next + 1'b1) : rem_next;
    assign div0_rem     = orig_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            orig_q <= '0;
        end else if (state == IDLE && start) begin
            neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r  <= dividend[WIDTH-1];
            orig_q <= dividend;
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign q_out        = quo_next;
    assign r_out        = rem_next;
    // No iterations run on divide by zero, so quo_q still holds the dividend.
    assign div0_rem     = quo_q;
`endif

    assign state_dbg = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            div0_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_q  <= '0;
                        quo_q  <= dividend_mag;
                        dvs_q  <= divisor_mag;
                        cnt    <= '0;
                        div0_q <= (divisor == '0);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (div0_q) begin
                        quotient    <= DIV0_QUOTIENT;
                        remainder   <= div0_rem;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            quotient    <= q_out;
                            remainder   <= r_out;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
